// File: rtl/password_checker.sv
// Collects LENGTH streamed characters per candidate, compares against a loaded target, counts attempts.
// Verdict one cycle after the last character; charReady drops in COMPARE and FOUND, so upstream stalls.
module password_checker #(
    parameter int LENGTH = 4,
    parameter int CHAR_W = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       targetLoad,
    input  logic [LENGTH*CHAR_W-1:0]   targetIn,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       charValid,
    input  logic [CHAR_W-1:0]          charIn,
    output logic                       charReady,
    output logic                       busy,
    output logic                       found,
    output logic [LENGTH*CHAR_W-1:0]   foundPassword,
    output logic [31:0]                attempts
);

    localparam int PW_W   = LENGTH * CHAR_W;
    localparam int SLOT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPARE,
        S_FOUND
    } state_t;

    state_t            state;
    logic [PW_W-1:0]   target;
    logic [PW_W-1:0]   candidate;
    logic [SLOT_W-1:0] slot;
    logic              match;
    logic              xfer;

    // Raw bytewise comparison; no character-class filtering.
    always_comb begin
        match = 1'b1;
        for (int i = 0; i < LENGTH; i++) begin
            if (candidate[i*CHAR_W +: CHAR_W] != target[i*CHAR_W +: CHAR_W]) begin
                match = 1'b0;
            end
        end
    end

    // charReady is high only in COLLECT, so this also gates on state.
    assign xfer = charValid && charReady;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            target        <= '0;
            candidate     <= '0;
            slot          <= '0;
            charReady     <= 1'b0;
            busy          <= 1'b0;
            found         <= 1'b0;
            foundPassword <= '0;
            attempts      <= '0;
        end else begin
            if (targetLoad && (state == S_IDLE || state == S_FOUND)) begin
                target <= targetIn;
            end

            if (stop) begin
                state         <= S_IDLE;
                slot          <= '0;
                charReady     <= 1'b0;
                busy          <= 1'b0;
                found         <= 1'b0;
                foundPassword <= '0;
            end else if (start) begin
                // Restart from any state; a pending compare is dropped.
                state         <= S_COLLECT;
                candidate     <= '0;
                slot          <= '0;
                charReady     <= 1'b1;
                busy          <= 1'b1;
                found         <= 1'b0;
                foundPassword <= '0;
                attempts      <= '0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        if (xfer) begin
                            candidate <= {candidate[PW_W-CHAR_W-1:0], charIn};
                            if (slot == LAST_SLOT) begin
                                slot      <= '0;
                                state     <= S_COMPARE;
                                charReady <= 1'b0;
                            end else begin
                                slot <= slot + 1'b1;
                            end
                        end
                    end
                    S_COMPARE: begin
                        if (attempts != 32'hFFFF_FFFF) begin
                            attempts <= attempts + 32'd1;
                        end
                        if (match) begin
                            state         <= S_FOUND;
                            busy          <= 1'b0;
                            found         <= 1'b1;
                            foundPassword <= candidate;
                        end else begin
                            state     <= S_COLLECT;
                            charReady <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_password_checker.sv
// Randomized bench for password_checker with a string-level reference model.
module tb_password_checker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        targetLoad = 1'b0;
    logic [31:0] targetIn = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        charValid = 1'b0;
    logic [7:0]  charIn = '0;
    logic        charReady;
    logic        busy;
    logic        found;
    logic [31:0] foundPassword;
    logic [31:0] attempts;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_target = '0;
    logic [31:0] exp_attempts = '0;
    logic        exp_found = 1'b0;
    logic [31:0] exp_fp = '0;

    password_checker #(.LENGTH(4), .CHAR_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .targetLoad(targetLoad), .targetIn(targetIn),
        .start(start), .stop(stop), .charValid(charValid), .charIn(charIn),
        .charReady(charReady), .busy(busy), .found(found),
        .foundPassword(foundPassword), .attempts(attempts)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] str2w(input string s);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w = {w[23:0], s[i]};
        return w;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++)
            w = {w[23:0], ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(97, 99))};
        return w;
    endfunction

    task automatic load_target(input logic [31:0] t, input bit honoured);
        targetLoad = 1'b1;
        targetIn   = t;
        @(negedge clock);
        targetLoad = 1'b0;
        targetIn   = $urandom;
        if (honoured) exp_target = t;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exp_attempts = '0;
        exp_found    = 1'b0;
        exp_fp       = '0;
        check("start_ready", charReady, 1);
        check("start_busy", busy, 1);
        check("start_found", found, 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        exp_found = 1'b0;
        exp_fp    = '0;
        check("stop_busy", busy, 0);
        check("stop_found", found, 0);
        check("stop_fp", foundPassword, 0);
        check("stop_attempts", attempts, exp_attempts);
    endtask

    // Offers one character; upstream holds it until charReady is seen high before an edge.
    task automatic send_char(input logic [7:0] c, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                charValid = 1'b0;
                charIn    = 8'($urandom);
                @(negedge clock);
            end
        end
        charValid = 1'b1;
        charIn    = c;
        n = 0;
        while (charReady !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("ready_timeout", 0, 1);
        @(negedge clock);
        charValid = 1'b0;
        charIn    = 8'($urandom);
    endtask

    task automatic send_cand(input logic [31:0] cand, input bit gaps);
        bit m;
        for (int i = 3; i >= 0; i--) send_char(cand[i*8 +: 8], gaps);
        check("cmp_ready", charReady, 0);
        check("cmp_busy", busy, 1);
        check("cmp_found", found, 0);
        @(negedge clock);
        m = (cand == exp_target);
        if (exp_attempts != 32'hFFFF_FFFF) exp_attempts++;
        if (m) begin
            exp_found = 1'b1;
            exp_fp    = cand;
        end
        check("res_found", found, exp_found);
        check("res_fp", foundPassword, exp_fp);
        check("res_attempts", attempts, exp_attempts);
        check("res_ready", charReady, !m);
        check("res_busy", busy, !m);
    endtask

    initial begin
        #12;
        check("rst_ready", charReady, 0);
        check("rst_busy", busy, 0);
        check("rst_found", found, 0);
        check("rst_fp", foundPassword, 0);
        check("rst_attempts", attempts, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_ready", charReady, 0);

        // Basic match with valid held high.
        load_target(str2w("abcd"), 1);
        do_start();
        send_cand(str2w("abcd"), 0);
        @(negedge clock);
        check("found_hold", found, 1);
        check("found_ready", charReady, 0);
        do_stop();

        // Two misses then a hit.
        do_start();
        send_cand(str2w("aaaa"), 0);
        send_cand(str2w("abcc"), 0);
        send_cand(str2w("abcd"), 0);

        // Randomly gapped valid.
        do_start();
        send_cand(str2w("abcd"), 1);

        // Restart after a partial candidate.
        do_start();
        send_char("a", 0);
        send_char("b", 0);
        do_start();
        send_cand(str2w("abcd"), 1);
        check("restart_attempts", attempts, 1);

        // start+stop together, and targetLoad ignored while collecting.
        do_start();
        send_char("x", 0);
        load_target(str2w("zzzz"), 0);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        exp_found = 1'b0;
        exp_fp    = '0;
        check("ss_busy", busy, 0);
        check("ss_found", found, 0);
        check("ss_ready", charReady, 0);
        do_start();
        send_cand(str2w("abcd"), 0);

        // Asynchronous reset mid-candidate.
        do_start();
        send_cand(str2w("zzzz"), 0);
        send_char("a", 0);
        send_char("b", 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ready", charReady, 0);
        check("arst_busy", busy, 0);
        check("arst_found", found, 0);
        check("arst_fp", foundPassword, 0);
        check("arst_attempts", attempts, 0);
        exp_target = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", charReady, 0);
        check("post_rst_busy", busy, 0);
        do_start();
        send_cand(32'h0000_0000, 0);
        do_stop();

        // Randomized targets and candidates, including non-letter bytes.
        for (int it = 0; it < 25; it++) begin
            load_target(rand_word(), 1);
            do_start();
            for (int k = 0; k < 4; k++) begin
                if (exp_found) break;
                send_cand(($urandom_range(0, 2) == 0) ? exp_target : rand_word(), 1);
            end
            do_stop();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
